// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for a 5-stage RV32I core.
// Holds the instruction moving from ID into EX. It also produces the EX operand-forwarding
// selects, and it detects load-use hazards and inserts bubbles for them.
//
// Valid semantics: id_valid_i marks a real instruction in ID, and ex_valid_o marks a real
// instruction in EX. There is no ready signal. Back-pressure comes only from stall_i, which
// freezes this stage, and from load_use_stall_o, which tells the front end to hold PC and
// IF/ID while this stage loads a bubble.
module id_ex_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [31:0]       id_pc_i,
  input  logic [31:0]       id_rs1_data_i,
  input  logic [31:0]       id_rs2_data_i,
  input  logic [31:0]       id_imm_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [4:0]        ex_mem_rd_i,
  input  logic              ex_mem_reg_write_i,
  input  logic [4:0]        mem_wb_rd_i,
  input  logic              mem_wb_reg_write_i,
  output logic              ex_valid_o,
  output logic [31:0]       ex_pc_o,
  output logic [31:0]       ex_rs1_data_o,
  output logic [31:0]       ex_rs2_data_o,
  output logic [31:0]       ex_imm_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  logic load_use;

  // Forward select for one source index. EX/MEM is checked first because it holds the
  // newer value. x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_REG;
    if (ex_mem_reg_write_i && (ex_mem_rd_i != 5'd0) && (ex_mem_rd_i == rs))
      sel = FWD_EX_MEM;
    else if (mem_wb_reg_write_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rs))
      sel = FWD_MEM_WB;
    return sel;
  endfunction

  // Load-use hazard: a load in EX writes a register that the ID instruction reads.
  // A redirect kills the ID instruction, so the hazard is dropped during flush.
  always_comb begin
    load_use = 1'b0;
    if (!flush_i && ex_valid_o && ex_ctrl_o[1] && (ex_rd_addr_o != 5'd0) && id_valid_i &&
        ((ex_rd_addr_o == id_rs1_addr_i) || (ex_rd_addr_o == id_rs2_addr_i)))
      load_use = 1'b1;
  end

  assign load_use_stall_o = load_use;

  // Operand forwarding selects. A bubble in EX never forwards.
  always_comb begin
    fwd_a_o = FWD_REG;
    fwd_b_o = FWD_REG;
    if (ex_valid_o) begin
      fwd_a_o = fwd_sel(ex_rs1_addr_o);
      fwd_b_o = fwd_sel(ex_rs2_addr_o);
    end
  end

  // Stage register. Priority: hold, then flush bubble, then load-use bubble (counted),
  // then capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_ctrl_o     <= '0;
      bubble_cnt_o  <= '0;
    end else if (stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (flush_i || load_use) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_ctrl_o     <= '0;
      if (!flush_i)
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end else begin
      ex_valid_o    <= id_valid_i;
      ex_pc_o       <= id_pc_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_rs1_addr_o <= id_rs1_addr_i;
      ex_rs2_addr_o <= id_rs2_addr_i;
      ex_rd_addr_o  <= id_rd_addr_i;
      ex_ctrl_o     <= id_ctrl_i;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg. It drives directed vectors into two instances: one with
// default parameters and one with a 2-bit bubble counter. A behavioural model of the
// instruction in EX is checked against the DUT outputs on every falling edge. Literal
// expectations at key points pin the model itself.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [7:0]  id_ctrl = '0;
  logic [4:0]  em_rd = '0, mw_rd = '0;
  logic        em_we = 1'b0, mw_we = 1'b0;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a, fwd_b;
  logic        lu_stall;
  logic [15:0] bubble_cnt;

  logic        u2_valid;
  logic [31:0] u2_pc, u2_rs1_data, u2_rs2_data, u2_imm;
  logic [4:0]  u2_rs1, u2_rs2, u2_rd;
  logic [7:0]  u2_ctrl;
  logic [1:0]  u2_fwd_a, u2_fwd_b;
  logic        u2_lu;
  logic [1:0]  u2_cnt;

  int total = 0;
  int bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data),
    .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_rs1_addr_i(id_rs1),
    .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd), .id_ctrl_i(id_ctrl),
    .ex_mem_rd_i(em_rd), .ex_mem_reg_write_i(em_we), .mem_wb_rd_i(mw_rd),
    .mem_wb_reg_write_i(mw_we), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm),
    .ex_rs1_addr_o(ex_rs1), .ex_rs2_addr_o(ex_rs2), .ex_rd_addr_o(ex_rd),
    .ex_ctrl_o(ex_ctrl), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .load_use_stall_o(lu_stall), .bubble_cnt_o(bubble_cnt)
  );

  id_ex_stage_reg #(.CTRL_W(8), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data),
    .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_rs1_addr_i(id_rs1),
    .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd), .id_ctrl_i(id_ctrl),
    .ex_mem_rd_i(em_rd), .ex_mem_reg_write_i(em_we), .mem_wb_rd_i(mw_rd),
    .mem_wb_reg_write_i(mw_we), .ex_valid_o(u2_valid), .ex_pc_o(u2_pc),
    .ex_rs1_data_o(u2_rs1_data), .ex_rs2_data_o(u2_rs2_data), .ex_imm_o(u2_imm),
    .ex_rs1_addr_o(u2_rs1), .ex_rs2_addr_o(u2_rs2), .ex_rd_addr_o(u2_rd),
    .ex_ctrl_o(u2_ctrl), .fwd_a_o(u2_fwd_a), .fwd_b_o(u2_fwd_b),
    .load_use_stall_o(u2_lu), .bubble_cnt_o(u2_cnt)
  );

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model holds the instruction currently sitting in EX, plus the number of load-use
  // bubbles inserted since reset.
  logic        m_valid;
  logic [31:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [7:0]  m_ctrl;
  int          m_bubbles;

  // Which producer supplies the newest value of register rs. A bubble or x0 uses the file.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (!m_valid || rs == 0) return 2'd0;
    if (em_we && em_rd == rs) return 2'd2;
    if (mw_we && mw_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  // True when EX holds a load whose destination register the ID instruction reads.
  function automatic logic exp_load_use();
    logic ex_is_load;
    logic id_reads_it;
    ex_is_load  = m_valid && m_ctrl[1] && m_rd != 0;
    id_reads_it = id_valid && (id_rs1 == m_rd || id_rs2 == m_rd);
    return !flush && ex_is_load && id_reads_it;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_pc = 0; m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
  endtask

  initial begin
    model_clear();
    m_bubbles = 0;
  end

  // On every falling edge, compare the DUT against the model. When not in reset, also
  // advance the model to the state it will hold after the next rising edge.
  always @(negedge clk) begin
    logic lu;
    if (rst) begin
      model_clear();
      m_bubbles = 0;
    end
    lu = exp_load_use();
    chk("m_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("m_pc", ex_pc, m_pc);
    chk("m_rs1_data", ex_rs1_data, m_rs1_data);
    chk("m_rs2_data", ex_rs2_data, m_rs2_data);
    chk("m_imm", ex_imm, m_imm);
    chk("m_rs1", {27'd0, ex_rs1}, {27'd0, m_rs1});
    chk("m_rs2", {27'd0, ex_rs2}, {27'd0, m_rs2});
    chk("m_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    chk("m_ctrl", {24'd0, ex_ctrl}, {24'd0, m_ctrl});
    chk("m_fwd_a", {30'd0, fwd_a}, {30'd0, exp_fwd(m_rs1)});
    chk("m_fwd_b", {30'd0, fwd_b}, {30'd0, exp_fwd(m_rs2)});
    chk("m_lu", {31'd0, lu_stall}, {31'd0, lu});
    chk("m_cnt16", {16'd0, bubble_cnt}, m_bubbles % 65536);
    chk("m_cnt2", {30'd0, u2_cnt}, m_bubbles % 4);
    chk("m_u2_valid", {31'd0, u2_valid}, {31'd0, m_valid});
    if (!rst && !stall) begin
      if (flush || lu) begin
        model_clear();
        if (!flush) m_bubbles++;
      end else begin
        m_valid = id_valid; m_pc = id_pc; m_rs1_data = id_rs1_data;
        m_rs2_data = id_rs2_data; m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
        m_rd = id_rd; m_ctrl = id_ctrl;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [7:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_ctrl = ctrl;
  endtask

  task automatic set_fwd(input logic [4:0] erd, input logic ewe, input logic [4:0] wrd,
                         input logic wwe);
    em_rd = erd; em_we = ewe; mw_rd = wrd; mw_we = wwe;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    step();
    step();
    rst = 1'b0;

    // Pass-through into EX.
    set_id(1, 32'h100, 32'h11, 32'h22, 32'h4, 5'd1, 5'd2, 5'd5, 8'h01);
    step();
    chk("pt_valid", {31'd0, ex_valid}, 1);
    chk("pt_pc", ex_pc, 32'h100);
    chk("pt_rs1_data", ex_rs1_data, 32'h11);
    chk("pt_rd", {27'd0, ex_rd}, 5);
    chk("pt_ctrl", {24'd0, ex_ctrl}, 32'h01);

    // Forward priority on operand A. EX holds rs1=3, rs2=4.
    set_id(1, 32'h104, 32'h33, 32'h44, 32'h0, 5'd3, 5'd4, 5'd6, 8'h01);
    step();
    set_fwd(5'd3, 1, 5'd3, 1);
    #1 chk("fwd_both", {30'd0, fwd_a}, 2);
    chk("fwd_b_none", {30'd0, fwd_b}, 0);
    set_fwd(5'd3, 0, 5'd4, 1);
    #1 chk("fwd_memwb", {30'd0, fwd_a}, 0);
    chk("fwd_b_memwb", {30'd0, fwd_b}, 1);
    set_fwd(5'd3, 0, 5'd3, 1);
    #1 chk("fwd_drop_em", {30'd0, fwd_a}, 1);
    set_id(1, 32'h108, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, 8'h01);
    step();
    set_fwd(5'd0, 1, 5'd0, 1);
    #1 chk("fwd_x0", {30'd0, fwd_a}, 0);
    // A bubble in EX never forwards, even when its address fields match.
    set_id(0, 32'h10c, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0, 8'h00);
    step();
    set_fwd(5'd3, 1, 5'd3, 1);
    #1 chk("fwd_invalid", {30'd0, fwd_a}, 0);
    set_fwd(5'd0, 0, 5'd0, 0);

    // Load-use: lw x7 in EX, then add x9, x8, x7 in ID.
    set_id(1, 32'h200, 32'h0, 32'h0, 32'h10, 5'd1, 5'd0, 5'd7, 8'h03);
    step();
    set_id(1, 32'h204, 32'h8, 32'h7, 32'h0, 5'd8, 5'd7, 5'd9, 8'h01);
    #1 chk("lu_detect", {31'd0, lu_stall}, 1);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 0);
    chk("lu_bubble_pc", ex_pc, 0);
    chk("lu_cnt", {16'd0, bubble_cnt}, 1);
    chk("lu_clear", {31'd0, lu_stall}, 0);
    step();
    set_fwd(5'd0, 0, 5'd7, 1);
    #1 chk("lu_add_pc", ex_pc, 32'h204);
    chk("lu_fwd_b", {30'd0, fwd_b}, 1);
    set_fwd(5'd0, 0, 5'd0, 0);

    // A load to x0 never stalls.
    set_id(1, 32'h220, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 8'h03);
    step();
    set_id(1, 32'h224, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 8'h01);
    #1 chk("lu_x0", {31'd0, lu_stall}, 0);
    step();

    // Flush hides a pending load-use, and the counter does not move.
    set_id(1, 32'h240, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, 8'h03);
    step();
    set_id(1, 32'h244, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0, 5'd2, 8'h01);
    flush = 1;
    #1 chk("lu_flush", {31'd0, lu_stall}, 0);
    step();
    flush = 0;
    chk("flush_valid", {31'd0, ex_valid}, 0);
    chk("flush_cnt", {16'd0, bubble_cnt}, 1);

    // Stall has priority over flush.
    set_id(1, 32'h300, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd10, 8'h01);
    step();
    set_id(1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd11, 8'h01);
    stall = 1; flush = 1;
    step();
    chk("stall_hold_valid", {31'd0, ex_valid}, 1);
    chk("stall_hold_pc", ex_pc, 32'h300);
    stall = 0;
    step();
    flush = 0;
    chk("unstall_bubble", {31'd0, ex_valid}, 0);
    chk("unstall_cnt", {16'd0, bubble_cnt}, 1);

    // Stall with a pending load-use holds the stage and leaves the counter unchanged.
    set_id(1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, 8'h03);
    step();
    set_id(1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0, 5'd12, 8'h01);
    stall = 1;
    #1 chk("stall_lu", {31'd0, lu_stall}, 1);
    step();
    chk("stall_lu_pc", ex_pc, 32'h400);
    chk("stall_lu_cnt", {16'd0, bubble_cnt}, 1);
    stall = 0;
    step();
    chk("release_lu_cnt", {16'd0, bubble_cnt}, 2);
    step();
    chk("release_lu_pc", ex_pc, 32'h404);

    // Asynchronous reset in the middle of a cycle clears everything at once.
    #1 rst = 1;
    #1 chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_ctrl", {24'd0, ex_ctrl}, 0);
    chk("rst_cnt", {16'd0, bubble_cnt}, 0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 0);
    step();
    rst = 0;

    // Five load-use bubbles: the 16-bit counter reads 5, and the 2-bit counter wraps to 1.
    for (int i = 0; i < 5; i++) begin
      set_id(1, 32'h500 + 32'(i * 16), 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, 8'h03);
      step();
      set_id(1, 32'h504 + 32'(i * 16), 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd8, 8'h01);
      step();
      step();
    end
    chk("wrap_cnt16", {16'd0, bubble_cnt}, 5);
    chk("wrap_cnt2", {30'd0, u2_cnt}, 1);

    set_id(0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
